// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath; stalls on mem_ready.
// Optional JR support is compiled in with `define MIPS_CTRL_JR_EN.
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECUTE  = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALU_WB   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_ADDI_EX  = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_ADDI_WB  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(11);
`ifdef MIPS_CTRL_JR_EN
  localparam logic [STATE_W-1:0] S_JR       = STATE_W'(12);
  localparam logic [5:0]         FN_JR      = 6'b001000;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [STATE_W-1:0] state_q, state_d;

`ifndef MIPS_CTRL_JR_EN
  logic unused_funct;
  assign unused_funct = ^funct;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Memory handshake: MemRead/MemWrite act as valid and stay high while
  // waiting; a transfer completes in the cycle where mem_ready is also 1,
  // and only then does the FSM advance.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
`ifdef MIPS_CTRL_JR_EN
          OP_RTYPE:     state_d = (funct == FN_JR) ? S_JR : S_EXECUTE;
`else
          OP_RTYPE:     state_d = S_EXECUTE;
`endif
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALU_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUOp      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          if (!(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J})) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEMADR, S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALU_WB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 2'b01;
          PCSrc      = 2'b01;
          Branch     = 1'b1;
          instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
`ifdef MIPS_CTRL_JR_EN
        S_JR: begin
          PCSrc      = 2'b11;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Table-driven bench for mips_multicycle_control plus latency sequences.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic [1:0] alu_op, alu_src_b, pc_src;
  logic       alu_src_a, iord, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, pc_write, branch, instr_done, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .ALUOp(alu_op), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .PCSrc(pc_src),
    .IorD(iord), .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
    .RegDst(reg_dst), .MemtoReg(mem_to_reg), .RegWrite(reg_write),
    .PCWrite(pc_write), .Branch(branch), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  logic [17:0] act_ctrl;
  assign act_ctrl = {alu_op, alu_src_a, alu_src_b, pc_src, iord, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, pc_write, branch,
                     instr_done, illegal_op};

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTE = 4'd6, ALU_WB = 4'd7,
                         BRANCH = 4'd8, ADDI_EX = 4'd9, ADDI_WB = 4'd10, JUMP = 4'd11,
                         JR = 4'd12;
  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  localparam logic [17:0] SA = 18'h1 << 15, IORD = 18'h1 << 10, MR = 18'h1 << 9,
                          MW = 18'h1 << 8, IRW = 18'h1 << 7, RD = 18'h1 << 6,
                          M2R = 18'h1 << 5, RW = 18'h1 << 4, PCW = 18'h1 << 3,
                          BR = 18'h1 << 2, DONE = 18'h1 << 1, ILL = 18'h1;

  function automatic logic [17:0] aop(input logic [1:0] v); return {v, 16'b0}; endfunction
  function automatic logic [17:0] sb(input logic [1:0] v); return {3'b0, v, 13'b0}; endfunction
  function automatic logic [17:0] pcs(input logic [1:0] v); return {5'b0, v, 11'b0}; endfunction

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic [3:0] st;
    logic [17:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic [17:0] c_f_rdy, c_f_wait, c_dec, c_madr, c_mrd, c_mwb, c_mw_wait, c_mw_done;
  logic [17:0] c_exe, c_awb, c_brn, c_aex, c_awb_i, c_jmp, c_jr;

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [3:0] st, input logic [17:0] ctl);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Runs one instruction from FETCH with mem_ready high and counts cycles to instr_done.
  task automatic measure(input string name, input logic [5:0] op, input int exp_cycles);
    int  cycles = 0;
    logic done = 1'b0;
    @(negedge clk);
    rst = 1'b0; opcode = op; funct = 6'b100000; mem_ready = 1'b1;
    #1;
    chk({name, "_start_state"}, 32'(state), 32'(FETCH));
    for (int i = 0; i < 20 && !done; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      cycles++;
      if (instr_done) done = 1'b1;
    end
    chk({name, "_latency"}, done ? 32'(cycles) : 32'hffff_ffff, 32'(exp_cycles));
  endtask

  initial begin
    c_f_rdy   = MR | sb(2'b01) | IRW | PCW;
    c_f_wait  = MR | sb(2'b01);
    c_dec     = sb(2'b11);
    c_madr    = SA | sb(2'b10);
    c_mrd     = MR | IORD;
    c_mwb     = M2R | RW | DONE;
    c_mw_wait = MW | IORD;
    c_mw_done = MW | IORD | DONE;
    c_exe     = SA | aop(2'b10);
    c_awb     = RD | RW | DONE;
    c_brn     = SA | aop(2'b01) | pcs(2'b01) | BR | DONE;
    c_aex     = SA | sb(2'b10);
    c_awb_i   = RW | DONE;
    c_jmp     = pcs(2'b10) | PCW | DONE;
    c_jr      = pcs(2'b11) | PCW | DONE;

    // reset, then LW
    add(1, LW, 0, 1, FETCH, 18'h0);
    add(1, LW, 0, 1, FETCH, 18'h0);
    add(0, LW, 0, 1, FETCH, c_f_rdy);
    add(0, LW, 0, 1, DECODE, c_dec);
    add(0, LW, 0, 1, MEMADR, c_madr);
    add(0, BAD, 0, 1, MEMREAD, c_mrd);
    add(0, BAD, 0, 1, MEMWB, c_mwb);
    // RTYPE add, then BEQ
    add(0, BAD, 0, 1, FETCH, c_f_rdy);
    add(0, RTYPE, 6'b100000, 1, DECODE, c_dec);
    add(0, BAD, 0, 1, EXECUTE, c_exe);
    add(0, BAD, 0, 1, ALU_WB, c_awb);
    add(0, BEQ, 0, 1, FETCH, c_f_rdy);
    add(0, BEQ, 0, 1, DECODE, c_dec);
    add(0, BEQ, 0, 1, BRANCH, c_brn);
    // SW with three stalled MEMWRITE cycles
    add(0, SW, 0, 1, FETCH, c_f_rdy);
    add(0, SW, 0, 1, DECODE, c_dec);
    add(0, SW, 0, 1, MEMADR, c_madr);
    add(0, LW, 0, 0, MEMWRITE, c_mw_wait);
    add(0, LW, 0, 0, MEMWRITE, c_mw_wait);
    add(0, LW, 0, 0, MEMWRITE, c_mw_wait);
    add(0, LW, 0, 1, MEMWRITE, c_mw_done);
    // fetch stall, ADDI, J
    add(0, ADDI, 0, 0, FETCH, c_f_wait);
    add(0, ADDI, 0, 1, FETCH, c_f_rdy);
    add(0, ADDI, 0, 1, DECODE, c_dec);
    add(0, ADDI, 0, 1, ADDI_EX, c_aex);
    add(0, ADDI, 0, 1, ADDI_WB, c_awb_i);
    add(0, J, 0, 1, FETCH, c_f_rdy);
    add(0, J, 0, 1, DECODE, c_dec);
    add(0, J, 0, 1, JUMP, c_jmp);
    // illegal opcode, then reset during a MEMREAD stall
    add(0, BAD, 0, 1, FETCH, c_f_rdy);
    add(0, BAD, 0, 1, DECODE, c_dec | ILL | DONE);
    add(0, LW, 0, 1, FETCH, c_f_rdy);
    add(0, LW, 0, 1, DECODE, c_dec);
    add(0, LW, 0, 1, MEMADR, c_madr);
    add(0, LW, 0, 0, MEMREAD, c_mrd);
    add(1, LW, 0, 0, MEMREAD, 18'h0);
    // RTYPE with funct 001000
    add(0, RTYPE, 6'b001000, 1, FETCH, c_f_rdy);
    add(0, RTYPE, 6'b001000, 1, DECODE, c_dec);
`ifdef MIPS_CTRL_JR_EN
    add(0, RTYPE, 6'b001000, 1, JR, c_jr);
`else
    add(0, RTYPE, 6'b001000, 1, EXECUTE, c_exe);
    add(0, RTYPE, 6'b001000, 1, ALU_WB, c_awb);
`endif

    rst = 1'b1; opcode = 6'b0; funct = 6'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].op; funct = vecs[i].fn; mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(act_ctrl), 32'(vecs[i].ctl));
    end

    measure("lw", LW, 5);
    measure("sw", SW, 4);
    measure("rtype", RTYPE, 4);
    measure("addi", ADDI, 4);
    measure("beq", BEQ, 3);
    measure("j", J, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences the shared ALU, PC, instruction register, register file and unified memory across FETCH/DECODE/EXECUTE/MEM/WB cycles.
- Drives the 2-bit ALUOp into the existing ALU-control decoder:
  - 00 = add
  - 01 = sub
  - 10 = decode by funct
- Sits between the instruction register (opcode/funct) and the datapath muxes/enables; stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register and the `state` debug port.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- funct  input  6  instr[5:0]; used only by the optional JR feature.
- mem_ready  input  1  memory has data (read) or accepted write this cycle.
- ALUOp  output  2  to ALU-control decoder.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- PCSrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target, 11 = register A (JR).
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load instruction register.
- RegDst  output  1  0 = rt, 1 = rd.
- MemtoReg  output  1  0 = ALUOut, 1 = memory data register.
- RegWrite  output  1  register-file write enable.
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  PC load if ALU zero.
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode.
- state  output  STATE_W  current state, for debug.

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- On reset:
  - state <= FETCH.
  - While rst = 1, every output other than `state` is forced to 0.
- Output decoding:
  - Outputs are combinational from state.
  - Memory-state enables are additionally gated by mem_ready.
  - Any output not listed for a state is 0.
- Supported opcodes:
  - RTYPE = 000000
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- States and transitions:
  - FETCH:
    - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00.
    - IRWrite and PCWrite are asserted only when mem_ready = 1.
    - Next: DECODE if mem_ready = 1, else remain in FETCH (no PC or IR change).
  - DECODE:
    - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
    - Next by opcode: LW/SW -> MEMADR, RTYPE -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDI_EX, J -> JUMP.
    - Any other opcode: pulse illegal_op and instr_done, return to FETCH.
  - MEMADR:
    - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
    - Next: MEMREAD if LW, MEMWRITE if SW.
  - MEMREAD:
    - Outputs: MemRead = 1, IorD = 1.
    - Next: MEMWB when mem_ready = 1, else hold.
  - MEMWB:
    - Outputs: RegDst = 0, MemtoReg = 1, RegWrite = 1, instr_done = 1.
    - Next: FETCH.
  - MEMWRITE:
    - Outputs: MemWrite = 1, IorD = 1.
    - When mem_ready = 1: instr_done = 1 and go to FETCH; otherwise hold with MemWrite still high.
  - EXECUTE:
    - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10.
    - Next: ALU_WB.
  - ALU_WB:
    - Outputs: RegDst = 1, MemtoReg = 0, RegWrite = 1, instr_done = 1.
    - Next: FETCH.
  - BRANCH:
    - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 01, Branch = 1, instr_done = 1.
    - Next: FETCH.
  - ADDI_EX:
    - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00.
    - Next: ADDI_WB.
  - ADDI_WB:
    - Outputs: RegDst = 0, MemtoReg = 0, RegWrite = 1, instr_done = 1.
    - Next: FETCH.
  - JUMP:
    - Outputs: PCSrc = 10, PCWrite = 1, instr_done = 1.
    - Next: FETCH.
- Latency with mem_ready held high, in cycles:
  - LW = 5
  - SW = 4
  - RTYPE = 4
  - ADDI = 4
  - BEQ = 3
  - J = 3
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Opcode is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- rst asserted in any state, including mid-stall: next state is FETCH, and no write enable is asserted in the rst cycle.
- Unused state encodings go to FETCH.

Optional Feature:
- Macro: MIPS_CTRL_JR_EN.
- Defined:
  - In DECODE, RTYPE with funct = 001000 goes to state JR instead of EXECUTE.
  - JR outputs: PCSrc = 11, PCWrite = 1, instr_done = 1; next FETCH.
  - JR takes 3 cycles; no register write.
- Undefined:
  - No JR state exists and funct is ignored.
  - funct 001000 follows the normal RTYPE path: EXECUTE, then ALU_WB.

Test Plan:
1. Reset: rst = 1 for 2 cycles, mem_ready = 1 -> state = FETCH, all control outputs 0; on the first cycle after release, MemRead = 1, ALUSrcB = 01, IRWrite = 1, PCWrite = 1.
2. LW (opcode 100011), mem_ready = 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; MEMWB has RegWrite = 1 and MemtoReg = 1; instr_done pulses once, at cycle 5.
3. RTYPE add (opcode 000000), then BEQ (000100) -> EXECUTE has ALUOp = 10; ALU_WB has RegDst = 1 and RegWrite = 1; BRANCH has ALUOp = 01, Branch = 1, PCSrc = 01; totals 4 and 3 cycles.
4. SW with mem_ready low for 3 cycles in MEMWRITE -> MemWrite held high for 4 cycles, instr_done only on the cycle mem_ready = 1, and RegWrite never asserted.
5. Opcode 111111 -> illegal_op and instr_done pulse in DECODE, return to FETCH; then rst pulsed in MEMREAD during a stall -> next state FETCH, RegWrite never asserted.
6. With MIPS_CTRL_JR_EN: RTYPE, funct 001000 -> JR state with PCSrc = 11, PCWrite = 1, no RegWrite, 3 cycles. Without the macro: the same instruction passes through EXECUTE and ALU_WB.
